spi_tx_burst: RTL
=================

Name: spi_tx_burst

Overview:
- Parametrised serial transmitter driving write-only SPI-style peripherals (LED/segment drivers) from an internal data stream.
- Generalises the fixed 8-bit LSB-first transmitter: configurable word width, bit order and clock divider.
- Supports multi-word bursts with the strobe held active across words.
- Sits between a command sequencer (ready/ack handshake) and the device pins (stb/clk/dio).

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- CYCLES, 1: clock divider; each dev_clk half-period lasts CYCLES+1 clk cycles; legal range 0..255.
- LSB_FIRST, 1: 1 transmits bit 0 first; 0 transmits bit WIDTH-1 first.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- data_rdy  input  1  word available on data/data_last.
- data  input  WIDTH  word to transmit.
- data_last  input  1  1 ends the frame after this word; 0 continues the burst.
- data_ack  output  1  one-cycle pulse; word captured.
- busy  output  1  shifting a word; data_rdy is ignored while high.
- done  output  1  one-cycle pulse; frame finished.
- dev_stb  output  1  device strobe, active-low.
- dev_clk  output  1  device clock; idles high.
- dev_dio  output  1  serial data out.

Behaviour:
- States: IDLE, LOAD, SETUP, HOLD, WAIT.
- Reset: state IDLE; busy=0, done=0, data_ack=0, dev_stb=1, dev_clk=1, dev_dio=0; shift register, bit counter and divider counter cleared.
- Reset mid-frame: the next cycle is IDLE with the reset values above. No done pulse. The frame is abandoned.
- Acceptance: in IDLE or WAIT with data_rdy=1, at the clk edge:
  - capture data into the shift register and data_last into a last flag;
  - go to LOAD.
- data_rdy in any other state is ignored; no capture, no ack.
- LOAD (1 cycle): data_ack=1; bit counter=0; divider=0; next state SETUP.
- SETUP (CYCLES+1 cycles): dev_clk=0; dev_dio = current bit. Then go to HOLD.
- HOLD (CYCLES+1 cycles): dev_clk=1; dev_dio unchanged, so the device samples on the rising edge. At the end of HOLD:
  - bit counter < WIDTH-1: increment it, advance the shift register, go to SETUP;
  - last flag=1: go to IDLE with done=1 in that first IDLE cycle;
  - last flag=0: go to WAIT.
- Current bit: bit[cnt] when LSB_FIRST=1; bit[WIDTH-1-cnt] when LSB_FIRST=0.
- WAIT: dev_stb=0, dev_clk=1, dev_dio=0, busy=0. Waits indefinitely for data_rdy.
- dev_stb:
  - 0 in SETUP, HOLD and WAIT;
  - 0 in LOAD when entered from WAIT;
  - 1 otherwise, including LOAD entered from IDLE.
- dev_dio=0 outside SETUP/HOLD.
- busy=1 in LOAD, SETUP and HOLD.
- Word latency: from the acceptance edge, 1 LOAD cycle + WIDTH*2*(CYCLES+1) shifting cycles.
- Counters: bit counter is $clog2(WIDTH) bits; divider is 8 bits and compares equal to CYCLES; neither wraps past its terminal value.
- IDLE-or-WAIT with data_rdy=1 on the same cycle as done: done still pulses; the new word is accepted normally.

Optional Feature:
- Macro: SPI_TX_BURST_RX_EN.
- Defined: adds input dev_din (1 bit), output rx_data (WIDTH), output rx_valid (1).
  - dev_din is sampled on the first clk cycle of each HOLD phase.
  - Bits are assembled into the same bit position as the bit transmitted in that slot.
  - At the end of each word's final HOLD, rx_data is updated and rx_valid pulses for 1 cycle.
  - Reset clears rx_data to 0 and rx_valid to 0.
- Undefined: these ports and all receive logic are absent; transmit behaviour is identical.

Test Plan:
- WIDTH=8, CYCLES=1, LSB_FIRST=1; data=8'hA5, data_last=1, accepted at cycle N:
  - data_ack at N+1;
  - dev_stb low for cycles N+2..N+33;
  - dev_dio bits 1,0,1,0,0,1,0,1, each stable 4 cycles;
  - 8 dev_clk rising edges;
  - done at N+34.
- WIDTH=16, CYCLES=0, LSB_FIRST=0; data=16'h8001:
  - dev_clk toggles every cycle;
  - dev_dio order is 1, fourteen 0s, then 1;
  - 32 shifting cycles.
- Burst with WIDTH=8, CYCLES=1: word 8'h0F with last=0, then 8'hF0 with last=1 delivered 5 cycles into WAIT:
  - dev_stb stays low continuously from the first SETUP to the end;
  - two data_ack pulses;
  - exactly one done pulse.
- data_rdy pulsed with data=8'hFF in mid-frame (busy=1) -> no data_ack; the transmitted word is unchanged.
- rst asserted during the 4th bit's HOLD -> next cycle dev_stb=1, dev_clk=1, dev_dio=0, busy=0, no done. The next accepted word transmits correctly from bit 0.
- With SPI_TX_BURST_RX_EN defined, dev_din tied to dev_dio (loopback), data=8'h3C -> rx_valid pulses with rx_data=8'h3C in the same cycle as done.

Source files
------------

// File: rtl/spi_tx_burst.sv
// spi_tx_burst: serial word transmitter for write-only SPI-style peripherals.
// Shifts WIDTH-bit words out on dev_dio, with dev_clk low for the setup half and
// high for the hold half, so the device samples on the rising edge. Words taken
// with data_last=0 keep dev_stb low so the next word continues the same frame.
// Optional receive path: define SPI_TX_BURST_RX_EN to add dev_din/rx_data/rx_valid.
module spi_tx_burst #(
  parameter int WIDTH     = 8,
  parameter int CYCLES    = 1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_rdy,
  input  logic [WIDTH-1:0] data,
  input  logic             data_last,
  output logic             data_ack,
  output logic             busy,
  output logic             done,
  output logic             dev_stb,
  output logic             dev_clk,
  output logic             dev_dio
`ifdef SPI_TX_BURST_RX_EN
  ,
  input  logic             dev_din,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
`endif
);

  localparam int             CW      = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);
  localparam logic [7:0]     DIV_MAX = 8'(CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [7:0]       div;
  logic             last_flag;
  logic             from_wait;

  logic             div_end;
  logic             bit_end;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_adv;

  // Phase/bit terminal conditions and the bit currently on the wire.
  // The register always presents the active bit at one end, so advancing it
  // walks bit[cnt] (LSB first) or bit[WIDTH-1-cnt] (MSB first) onto dev_dio.
  always_comb begin
    div_end = (div == DIV_MAX);
    bit_end = (cnt == CNT_MAX);
    if (LSB_FIRST) begin
      cur_bit   = shreg[0];
      shreg_adv = {1'b0, shreg[WIDTH-1:1]};
    end else begin
      cur_bit   = shreg[WIDTH-1];
      shreg_adv = {shreg[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: words are only taken between words (IDLE or WAIT).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_WAIT: if (data_rdy) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_SETUP;
      S_SETUP:        if (div_end) state_nxt = S_HOLD;
      S_HOLD: begin
        if (div_end) begin
          if (!bit_end)       state_nxt = S_SETUP;
          else if (last_flag) state_nxt = S_IDLE;
          else                state_nxt = S_WAIT;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Datapath: word capture, bit/divider counters, end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      div       <= '0;
      last_flag <= 1'b0;
      from_wait <= 1'b0;
      done      <= 1'b0;
    end else begin
      // done lands in the first IDLE cycle after the last word's final hold
      done <= (state == S_HOLD) && div_end && bit_end && last_flag;
      case (state)
        S_IDLE, S_WAIT: begin
          if (data_rdy) begin
            shreg     <= data;
            last_flag <= data_last;
            // a word taken from WAIT continues the frame, so the strobe stays low
            from_wait <= (state == S_WAIT);
          end
        end
        S_LOAD: begin
          cnt <= '0;
          div <= '0;
        end
        S_SETUP: begin
          div <= div_end ? 8'd0 : div + 8'd1;
        end
        S_HOLD: begin
          if (div_end) begin
            div <= 8'd0;
            if (!bit_end) begin
              cnt   <= cnt + 1'b1;
              shreg <= shreg_adv;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; dev_clk idles high, dev_dio idles low.
  always_comb begin
    busy     = 1'b0;
    data_ack = 1'b0;
    dev_stb  = 1'b1;
    dev_clk  = 1'b1;
    dev_dio  = 1'b0;
    case (state)
      S_LOAD: begin
        busy     = 1'b1;
        data_ack = 1'b1;
        dev_stb  = !from_wait;
      end
      S_SETUP: begin
        busy    = 1'b1;
        dev_stb = 1'b0;
        dev_clk = 1'b0;
        dev_dio = cur_bit;
      end
      S_HOLD: begin
        busy    = 1'b1;
        dev_stb = 1'b0;
        dev_dio = cur_bit;
      end
      S_WAIT: begin
        dev_stb = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef SPI_TX_BURST_RX_EN
  logic [WIDTH-1:0] rx_acc, rx_nxt;
  logic [CW-1:0]    rx_idx;
  logic             rx_sample;

  // Received bit goes to the same position as the bit sent in that slot.
  // The merged value is used for rx_data so a one-cycle hold still lands its bit.
  always_comb begin
    rx_idx    = LSB_FIRST ? cnt : CNT_MAX - cnt;
    rx_sample = (state == S_HOLD) && (div == 8'd0);
    rx_nxt    = rx_acc;
    if (rx_sample) rx_nxt[rx_idx] = dev_din;
  end

  // Receive assembly and per-word publish at the end of the final hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_acc   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_sample) rx_acc <= rx_nxt;
      if ((state == S_HOLD) && div_end && bit_end) begin
        rx_data  <= rx_nxt;
        rx_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
